// File: rtl/inv_cipher_if.sv
// Handshake bus for inv_cipher.
//   in_valid/in_ready : job request (key + ciphertext data)
//   out_valid/out_ready : plaintext result o
// master = job producer / result consumer, slave = the cipher core.
interface inv_cipher_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key;
    logic [127:0] data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] o;

    modport master (
        output in_valid, key, data, out_ready,
        input  in_ready, out_valid, o
    );

    modport slave (
        input  in_valid, key, data, out_ready,
        output in_ready, out_valid, o
    );
endinterface

// File: rtl/inv_cipher.sv
// Shared AES definitions plus the iterative AES-128 inverse cipher.
// aes_defs_pkg : GF(2^8) arithmetic, S-box / inverse S-box, Rcon.
// inv_cipher   : one decryption round per clock, key schedule expanded
//                forward to round key 10, then walked back per round.
// Ports: clk, rst (async, active-low), bus (inv_cipher_if.slave).
// Byte 0 of any 128-bit value is bits [127:120]; state is column-major.
package aes_defs_pkg;
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int unsigned i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned k);
        logic [15:0] t;
        t = {x, x} << k;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction
endpackage

module inv_cipher
    import aes_defs_pkg::*;
(
    input logic         clk,
    input logic         rst,
    inv_cipher_if.slave bus
);
    typedef enum logic [2:0] {IDLE, EXPAND, ROUND, FINAL, DONE} fsm_t;

    fsm_t         fsm;
    logic [3:0]   cnt;
    logic [127:0] key_reg;
    logic [127:0] data_reg;
    logic [127:0] state_reg;
    logic         in_ready_r;
    logic         out_valid_r;
    logic [127:0] o_r;

    logic [127:0] key_fwd;
    logic [127:0] key_inv;
    logic [127:0] inv_sr_sb;

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one expansion step: recover the upper words first, since the
    // old w3 is needed to rebuild the old w0.
    function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    // InvShiftRows followed by InvSubBytes: row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                t[127 - 8 * (4 * c + r) -: 8] = inv_sbox(s[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8]);
            end
        end
        return t;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        t = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            t[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            t[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            t[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            t[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return t;
    endfunction

    // During ROUND cnt holds r; FINAL runs with cnt = 0 so cnt+1 selects Rcon[1].
    always_comb begin
        key_fwd   = fwd_key(key_reg, rcon(cnt));
        key_inv   = inv_key(key_reg, rcon(cnt + 4'd1));
        inv_sr_sb = inv_shift_sub(state_reg);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm         <= IDLE;
            cnt         <= '0;
            key_reg     <= '0;
            data_reg    <= '0;
            state_reg   <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            o_r         <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (bus.in_valid && in_ready_r) begin
                        key_reg    <= bus.key;
                        data_reg   <= bus.data;
                        cnt        <= 4'd1;
                        in_ready_r <= 1'b0;
                        fsm        <= EXPAND;
                    end
                end
                EXPAND: begin
                    key_reg <= key_fwd;
                    cnt     <= cnt + 4'd1;
                    if (cnt == 4'd10) begin
                        state_reg <= data_reg ^ key_fwd;
                        cnt       <= 4'd9;
                        fsm       <= ROUND;
                    end
                end
                ROUND: begin
                    key_reg   <= key_inv;
                    state_reg <= inv_mix(inv_sr_sb ^ key_inv);
                    cnt       <= cnt - 4'd1;
                    if (cnt == 4'd1) fsm <= FINAL;
                end
                FINAL: begin
                    key_reg     <= key_inv;
                    state_reg   <= inv_sr_sb ^ key_inv;
                    o_r         <= inv_sr_sb ^ key_inv;
                    out_valid_r <= 1'b1;
                    fsm         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        fsm         <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.o         = o_r;
endmodule
